// File: rtl/shifter_pkg.sv
// ---------------------------------------------------------------------------
// shifter_pkg
// Shared definitions for the ALU shifter group: default data / shift-amount
// widths, the iterative shifter state encoding and the shift-mode constants.
// ---------------------------------------------------------------------------
package shifter_pkg;

    localparam int DEF_WIDTH = 16;  // operand / result width
    localparam int DEF_SHW   = 4;   // shift-amount bits actually used

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic SH_LSR = 1'b0;  // logical right shift, zero fill
    localparam logic SH_ASR = 1'b1;  // arithmetic right shift, sign fill

endpackage : shifter_pkg

// File: rtl/rsh_step.sv
// ---------------------------------------------------------------------------
// rsh_step
// Combinational single-bit right step used by the iterative shifter.
// Ports:
//   work_i  in   WIDTH  current working value
//   mode_i  in   1      SH_LSR (zero fill) or SH_ASR (sign fill)
//   work_o  out  WIDTH  value shifted right by one
//   bit_o   out  1      bit shifted out (work_i[0])
// ---------------------------------------------------------------------------
module rsh_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] work_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] work_o,
    output logic             bit_o
);

    logic fill;

    // Sign fill replicates the current MSB, so repeated steps behave like >>>.
    assign fill   = (mode_i == SH_ASR) ? work_i[WIDTH-1] : 1'b0;
    assign work_o = {fill, work_i[WIDTH-1:1]};
    assign bit_o  = work_i[0];

endmodule : rsh_step

// File: rtl/rsh16_iter.sv
// ---------------------------------------------------------------------------
// rsh16_iter
// Multi-cycle right shifter (LSR / ASR), one bit per clock, with a
// start / busy / done handshake. Reports carry (last bit shifted out) and a
// zero flag alongside the registered result.
//
// Handshake: start is sampled on a rising edge only while busy is low (IDLE
// or DONE). The operation then runs for N = shift_value[SHW-1:0] edges with
// busy high; done pulses for exactly one cycle when out/carry/zero update.
// Holding start through DONE launches the next operation with no gap.
//
// Ports:
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous, active-low reset
//   start        in   1      operation request
//   arith        in   1      0 = LSR, 1 = ASR (sampled with start)
//   inp          in   WIDTH  operand (sampled with start)
//   shift_value  in   16     shift amount, only [SHW-1:0] used
//   busy         out  1      high while shifting
//   done         out  1      one-cycle completion pulse
//   out          out  WIDTH  result, held until the next completion
//   carry        out  1      last bit shifted out, 0 for amount 0
//   zero         out  1      out == 0
//   state_o      out  2      current FSM state (debug)
// ---------------------------------------------------------------------------
module rsh16_iter
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             arith,
    input  logic [WIDTH-1:0] inp,
    input  logic [15:0]      shift_value,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero,
    output logic [1:0]       state_o
);

    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
    localparam logic [SHW-1:0] CNT_ZERO = '0;

    state_t           state_q;
    logic [WIDTH-1:0] work_q;
    logic             mode_q;
    logic [SHW-1:0]   count_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] out_q;
    logic             carry_q;
    logic             zero_q;

    logic [WIDTH-1:0] step_work;
    logic             step_bit;
    logic [SHW-1:0]   amount;

    // Upper shift-amount bits are deliberately ignored.
    logic             unused_amount_bits;
    assign unused_amount_bits = &{1'b0, shift_value[15:SHW]};

    assign amount = shift_value[SHW-1:0];

    rsh_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .work_i (work_q),
        .mode_i (mode_q),
        .work_o (step_work),
        .bit_o  (step_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            mode_q  <= SH_LSR;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    work_q  <= step_work;
                    count_q <= count_q - CNT_ONE;
                    // Final step: publish the shifted value straight from the
                    // step logic so the result lands on the same edge.
                    if (count_q == CNT_ONE) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        out_q   <= step_work;
                        carry_q <= step_bit;
                        zero_q  <= (step_work == '0);
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                    if (start) begin
                        work_q  <= inp;
                        mode_q  <= arith;
                        count_q <= amount;
                        if (amount == CNT_ZERO) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            out_q   <= inp;
                            carry_q <= 1'b0;
                            zero_q  <= (inp == '0);
                        end else begin
                            state_q <= ST_SHIFT;
                            busy_q  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign out     = out_q;
    assign carry   = carry_q;
    assign zero    = zero_q;
    assign state_o = state_q;

endmodule : rsh16_iter

// File: tb/tb_rsh16_iter.sv
module tb_rsh16_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        arith;
    logic [15:0] inp;
    logic [15:0] shift_value;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic        carry;
    logic        zero;
    logic [1:0]  state_o;

    always #5 clk = ~clk;

    rsh16_iter dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .arith       (arith),
        .inp         (inp),
        .shift_value (shift_value),
        .busy        (busy),
        .done        (done),
        .out         (out),
        .carry       (carry),
        .zero        (zero),
        .state_o     (state_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [15:0] ref_res(input logic [15:0] a, input logic ar, input int n);
        logic signed [15:0] s;
        s = a;
        if (ar) return s >>> n;
        else    return a >> n;
    endfunction

    function automatic logic ref_carry(input logic [15:0] a, input int n);
        if (n == 0) return 1'b0;
        return a[n-1];
    endfunction

    // ---------------- behavioural timing model ----------------
    // An accepted op with amount N completes on the edge N edges after the
    // accepting edge; nothing new is accepted until that completion edge has passed.
    int          e_cnt      = 0;
    logic        pend       = 1'b0;
    int          pend_done  = 0;
    logic [15:0] pend_res   = '0;
    logic        pend_c     = 1'b0;
    logic [15:0] m_out      = '0;
    logic        m_carry    = 1'b0;
    logic        m_zero     = 1'b1;
    logic        m_busy     = 1'b0;
    logic        m_done     = 1'b0;
    int          acc_cnt    = 0;
    int          m_done_cnt = 0;
    int          dut_done_cnt = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend    <= 1'b0;
            m_out   <= '0;
            m_carry <= 1'b0;
            m_zero  <= 1'b1;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
        end else begin
            e_cnt <= e_cnt + 1;
            if (pend && e_cnt == pend_done) begin
                pend       <= 1'b0;
                m_out      <= pend_res;
                m_carry    <= pend_c;
                m_zero     <= (pend_res == 16'h0);
                m_busy     <= 1'b0;
                m_done     <= 1'b1;
                m_done_cnt <= m_done_cnt + 1;
            end else if (!pend && start) begin
                acc_cnt <= acc_cnt + 1;
                if (shift_value[3:0] == 4'd0) begin
                    m_out      <= inp;
                    m_carry    <= 1'b0;
                    m_zero     <= (inp == 16'h0);
                    m_busy     <= 1'b0;
                    m_done     <= 1'b1;
                    m_done_cnt <= m_done_cnt + 1;
                end else begin
                    pend      <= 1'b1;
                    pend_done <= e_cnt + int'(shift_value[3:0]);
                    pend_res  <= ref_res(inp, arith, int'(shift_value[3:0]));
                    pend_c    <= ref_carry(inp, int'(shift_value[3:0]));
                    m_busy    <= 1'b1;
                    m_done    <= 1'b0;
                end
            end else begin
                m_done <= 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",  32'(busy),  32'(m_busy));
            chk("done",  32'(done),  32'(m_done));
            chk("out",   32'(out),   32'(m_out));
            chk("carry", 32'(carry), 32'(m_carry));
            chk("zero",  32'(zero),  32'(m_zero));
            chk("state", 32'(state_o), m_busy ? 32'd1 : (m_done ? 32'd2 : 32'd0));
            if (done === 1'b1) dut_done_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_op(input logic [15:0] a, input logic ar, input logic [15:0] sv,
                          input logic [15:0] e_out, input logic e_c, input logic e_z,
                          input int e_lat, input string name);
        int lat;
        int busy_n;
        logic got;
        lat = 0; busy_n = 0; got = 1'b0;
        @(posedge clk); #1;
        inp = a; arith = ar; shift_value = sv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) begin
                got = 1'b1;
                lat = k;
            end
        end
        chk({name, "_done_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({name, "_latency"}, 32'(lat), 32'(e_lat));
            chk({name, "_busy_cycles"}, 32'(busy_n), 32'(e_lat - 1));
            chk({name, "_out"}, 32'(out), 32'(e_out));
            chk({name, "_carry"}, 32'(carry), 32'(e_c));
            chk({name, "_zero"}, 32'(zero), 32'(e_z));
        end
    endtask

    task automatic wait_done(input string name, output logic got);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
        end
        chk({name, "_done_seen"}, 32'(got), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic got;
        int   base;
        int   guard;
        int   extra_done;

        rst = 1'b0; start = 1'b0; arith = 1'b0; inp = '0; shift_value = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out",   32'(out),   32'h0);
        chk("rst_carry", 32'(carry), 32'h0);
        chk("rst_zero",  32'(zero),  32'h1);
        chk("rst_busy",  32'(busy),  32'h0);
        chk("rst_done",  32'(done),  32'h0);
        @(posedge clk); #3;
        rst = 1'b1;
        chk_en = 1'b1;

        // directed cases with hand-computed results
        run_op(16'hF000, 1'b0, 16'd4,      16'h0F00, 1'b0, 1'b0, 5,  "lsr_f000_4");
        run_op(16'h8000, 1'b1, 16'd15,     16'hFFFF, 1'b0, 1'b0, 16, "asr_8000_15");
        run_op(16'hFF80, 1'b1, 16'd3,      16'hFFF0, 1'b0, 1'b0, 4,  "asr_ff80_3");
        run_op(16'h000B, 1'b0, 16'd1,      16'h0005, 1'b1, 1'b0, 2,  "lsr_000b_1");
        run_op(16'h0001, 1'b0, 16'd1,      16'h0000, 1'b1, 1'b1, 2,  "lsr_0001_1");
        run_op(16'hFFFF, 1'b0, 16'd0,      16'hFFFF, 1'b0, 1'b0, 1,  "amt0_ffff");
        run_op(16'h0080, 1'b0, 16'h0013,   16'h0010, 1'b0, 1'b0, 4,  "amt_upper_ignored");
        run_op(16'hC003, 1'b1, 16'd2,      16'hF000, 1'b1, 1'b0, 3,  "asr_c003_2");

        // start pulsed mid-shift is ignored
        @(posedge clk); #1;
        inp = 16'hA5A5; arith = 1'b0; shift_value = 16'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk); #1;
        inp = 16'hFFFF; arith = 1'b1; shift_value = 16'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("midstart", got);
        chk("midstart_out",   32'(out),   32'h0296);
        chk("midstart_carry", 32'(carry), 32'h1);
        extra_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done === 1'b1) extra_done++;
        end
        chk("midstart_no_second_done", 32'(extra_done), 32'h0);

        // start held through DONE: back-to-back
        @(posedge clk); #1;
        inp = 16'h00F0; arith = 1'b0; shift_value = 16'd2; start = 1'b1;
        @(posedge clk); #1;
        inp = 16'h8001; arith = 1'b1; shift_value = 16'd1;
        wait_done("b2b_first", got);
        chk("b2b_first_out",   32'(out),   32'h003C);
        chk("b2b_first_carry", 32'(carry), 32'h0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("b2b_second_busy", 32'(busy), 32'h1);
        wait_done("b2b_second", got);
        chk("b2b_second_out",   32'(out),   32'hC000);
        chk("b2b_second_carry", 32'(carry), 32'h1);

        // reset in the middle of a shift
        @(posedge clk); #1;
        inp = 16'hFFFF; arith = 1'b0; shift_value = 16'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk); #3;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out",  32'(out),  32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        chk("midrst_zero", 32'(zero), 32'h1);
        @(posedge clk); #3;
        rst = 1'b1;
        extra_done = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done === 1'b1) extra_done++;
        end
        chk("midrst_no_done", 32'(extra_done), 32'h0);
        run_op(16'h1234, 1'b0, 16'd8, 16'h0012, 1'b0, 1'b0, 9, "after_rst_lsr_1234_8");

        // random traffic with random gaps, mid-op starts and held starts
        base  = acc_cnt;
        guard = 0;
        while ((acc_cnt - base) < 1000 && guard < 60000) begin
            @(posedge clk); #1;
            start       = ($urandom_range(0, 2) == 0);
            inp         = 16'($urandom);
            arith       = 1'($urandom_range(0, 1));
            shift_value = 16'($urandom);
            guard++;
        end
        start = 1'b0;
        chk("random_within_budget", 32'(guard < 60000), 32'h1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("done_pulse_total", 32'(dut_done_cnt), 32'(m_done_cnt));

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rsh16_iter
